// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the CPU data-memory port.
// Each access takes three cycles (IDLE -> FETCH -> ACCESS). The addressed RAM
// word is fetched into a buffer, then either merged with store data and written
// back, or sliced and extended to form the load result. One word address maps
// to an 8-bit LED register instead of RAM.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] LED_ADDR    = 32'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        clk_stall,
    output logic [7:0]  led
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ACCESS
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        isStore_q, isStore_d;
    logic [31:0] readData_q, readData_d;
    logic        stall_q, stall_d;
    logic [7:0]  led_q, led_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] fetchWord_q;

    logic [IDX_W-1:0] wordIdx;
    logic             isByte;
    logic             isHalf;
    logic             isLed;
    logic             ramWe;
    logic [7:0]       byteSel;
    logic [15:0]      halfSel;
    logic [31:0]      mergedWord;
    logic [31:0]      loadValue;

    assign wordIdx = addr_q[IDX_W+1:2];
    assign isByte  = (mask_q[2:0] == 3'b001);
    assign isHalf  = (mask_q[2:0] == 3'b010);
    assign isLed   = (addr_q[31:2] == LED_ADDR[31:2]);

    assign read_data = readData_q;
    assign clk_stall = stall_q;
    assign led       = led_q;

    // Pick the addressed byte and halfword out of the fetched word.
    always_comb begin
        byteSel = fetchWord_q[7:0];
        case (addr_q[1:0])
            2'd0:    byteSel = fetchWord_q[7:0];
            2'd1:    byteSel = fetchWord_q[15:8];
            2'd2:    byteSel = fetchWord_q[23:16];
            default: byteSel = fetchWord_q[31:24];
        endcase
        halfSel = addr_q[1] ? fetchWord_q[31:16] : fetchWord_q[15:0];
    end

    // Replace only the selected lanes of the fetched word with store data.
    always_comb begin
        mergedWord = fetchWord_q;
        if (isByte) begin
            case (addr_q[1:0])
                2'd0:    mergedWord[7:0]   = wdata_q[7:0];
                2'd1:    mergedWord[15:8]  = wdata_q[7:0];
                2'd2:    mergedWord[23:16] = wdata_q[7:0];
                default: mergedWord[31:24] = wdata_q[7:0];
            endcase
        end else if (isHalf) begin
            if (addr_q[1]) begin
                mergedWord[31:16] = wdata_q[15:0];
            end else begin
                mergedWord[15:0] = wdata_q[15:0];
            end
        end else begin
            mergedWord = wdata_q;
        end
    end

    // Form the load result: LED readback, or a sign/zero-extended RAM slice.
    always_comb begin
        if (isLed) begin
            loadValue = {24'b0, led_q};
        end else if (isByte) begin
            loadValue = {{24{mask_q[3] & byteSel[7]}}, byteSel};
        end else if (isHalf) begin
            loadValue = {{16{mask_q[3] & halfSel[15]}}, halfSel};
        end else begin
            loadValue = fetchWord_q;
        end
    end

    // Next-state logic: latch a request in IDLE, wait a cycle for the RAM, then commit.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        isStore_d  = isStore_q;
        readData_d = readData_q;
        stall_d    = stall_q;
        led_d      = led_q;
        ramWe      = 1'b0;
        case (state_q)
            IDLE: begin
                if (memread || memwrite) begin
                    addr_d    = addr;
                    wdata_d   = write_data;
                    mask_d    = sign_mask;
                    isStore_d = memwrite;
                    stall_d   = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                stall_d = 1'b0;
                state_d = IDLE;
                if (isStore_q) begin
                    if (isLed) begin
                        led_d = wdata_q[7:0];
                    end else begin
                        ramWe = 1'b1;
                    end
                end else begin
                    readData_d = loadValue;
                end
            end
            default: begin
                stall_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            isStore_q  <= 1'b0;
            readData_q <= '0;
            stall_q    <= 1'b0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            isStore_q  <= isStore_d;
            readData_q <= readData_d;
            stall_q    <= stall_d;
            led_q      <= led_d;
        end
    end

    // Word-wide synchronous RAM with a fetch buffer loaded at the end of FETCH.
    always_ff @(posedge clk) begin
        if (ramWe) begin
            mem[wordIdx] <= mergedWord;
        end
        if (state_q == FETCH) begin
            fetchWord_q <= mem[wordIdx];
        end
    end

endmodule
